// File: rtl/jtvigil_rom_arb.sv
// Four-slot round-robin arbiter sharing one SDRAM bank read port among ROM requesters.
// Define JTVIGIL_ROM_ARB_CACHE_EN to keep each slot's last word valid across cs deassertion.
module jtvigil_rom_arb #(
  parameter int          AW    = 18,
  parameter logic [21:0] OFFS0 = 22'h0,
  parameter logic [21:0] OFFS1 = 22'h0,
  parameter logic [21:0] OFFS2 = 22'h0,
  parameter logic [21:0] OFFS3 = 22'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic          slot0_cs,
  input  logic [AW-1:0] slot0_addr,
  output logic [15:0]   slot0_data,
  output logic          slot0_ok,
  input  logic          slot1_cs,
  input  logic [AW-1:0] slot1_addr,
  output logic [15:0]   slot1_data,
  output logic          slot1_ok,
  input  logic          slot2_cs,
  input  logic [AW-1:0] slot2_addr,
  output logic [15:0]   slot2_data,
  output logic          slot2_ok,
  input  logic          slot3_cs,
  input  logic [AW-1:0] slot3_addr,
  output logic [15:0]   slot3_data,
  output logic          slot3_ok,
  output logic [21:0]   bus_addr,
  output logic          bus_rd,
  input  logic          bus_ack,
  input  logic          bus_rdy,
  input  logic [15:0]   bus_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t        state_r;
  logic [3:0]    cs_s;
  logic [3:0]    ok_s;
  logic [3:0]    pend_s;
  logic [3:0]    valid_r;
  logic [3:0]    valid_nxt_s;
  logic [AW-1:0] addr_s   [4];
  logic [AW-1:0] addr_l_r [4];
  logic [15:0]   data_r   [4];
  logic [21:0]   offs_s;
  logic [21:0]   fetch_addr_s;
  logic [1:0]    rr_r;
  logic [1:0]    gnt_r;
  logic [1:0]    gnt_s;
  logic          any_s;
  logic          grant_s;
  logic          store_s;

  assign cs_s      = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
  assign addr_s[0] = slot0_addr;
  assign addr_s[1] = slot1_addr;
  assign addr_s[2] = slot2_addr;
  assign addr_s[3] = slot3_addr;

  assign slot0_data = data_r[0];
  assign slot1_data = data_r[1];
  assign slot2_data = data_r[2];
  assign slot3_data = data_r[3];
  assign {slot3_ok, slot2_ok, slot1_ok, slot0_ok} = ok_s;

  // Per-slot hit detection and pending requests
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      ok_s[n] = valid_r[n] & cs_s[n] & (addr_s[n] == addr_l_r[n]);
    end
    pend_s = cs_s & ~ok_s;
  end

  // Round-robin pick: scan from rr+4 down to rr+1 so the nearest slot after rr wins
  always_comb begin
    logic [1:0] idx;
    idx   = 2'd0;
    gnt_s = rr_r;
    any_s = 1'b0;
    for (int i = 4; i >= 1; i--) begin
      idx = rr_r + 2'(i);
      if (pend_s[idx]) begin
        gnt_s = idx;
        any_s = 1'b1;
      end else begin
        any_s = any_s;
      end
    end
  end

  // Bank address of the candidate grant
  always_comb begin
    case (gnt_s)
      2'd0:    offs_s = OFFS0;
      2'd1:    offs_s = OFFS1;
      2'd2:    offs_s = OFFS2;
      default: offs_s = OFFS3;
    endcase
    fetch_addr_s = 22'(addr_s[gnt_s]) + offs_s;
  end

  assign grant_s = (state_r == ST_IDLE) & ~downloading & any_s;
  assign store_s = ((state_r == ST_REQ) & bus_ack & bus_rdy) | ((state_r == ST_WAIT) & bus_rdy);

  // Next valid flags: grant clears, store sets, downloading (and cs low when uncached) clears
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      logic keep;
      keep = (grant_s && gnt_s == 2'(n)) ? 1'b0 :
             (store_s && gnt_r == 2'(n)) ? 1'b1 : valid_r[n];
`ifdef JTVIGIL_ROM_ARB_CACHE_EN
      valid_nxt_s[n] = keep & ~downloading;
`else
      valid_nxt_s[n] = keep & ~downloading & cs_s[n];
`endif
    end
  end

  // Arbitration FSM, bus outputs and per-slot storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      bus_rd   <= 1'b0;
      bus_addr <= 22'd0;
      busy     <= 1'b0;
      rr_r     <= 2'd3;
      gnt_r    <= 2'd0;
      valid_r  <= 4'd0;
      for (int n = 0; n < 4; n++) begin
        addr_l_r[n] <= '0;
        data_r[n]   <= 16'd0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            gnt_r           <= gnt_s;
            rr_r            <= gnt_s;
            addr_l_r[gnt_s] <= addr_s[gnt_s];
            bus_addr        <= fetch_addr_s;
            bus_rd          <= 1'b1;
            busy            <= 1'b1;
            state_r         <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            bus_rd <= 1'b0;
            if (bus_rdy) begin
              busy    <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (bus_rdy) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          bus_rd  <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
      if (store_s) begin
        data_r[gnt_r] <= bus_data;
      end
      valid_r <= valid_nxt_s;
    end
  end

endmodule

// File: tb/tb_jtvigil_rom_arb.sv
// Self-checking bench for jtvigil_rom_arb: expected bank addresses are queued as requests
// are raised and popped as the arbiter issues reads; slot results are checked directly.
module tb_jtvigil_rom_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        downloading = 1'b0;
  logic        slot0_cs = 1'b0, slot1_cs = 1'b0, slot2_cs = 1'b0, slot3_cs = 1'b0;
  logic [17:0] slot0_addr = '0, slot1_addr = '0, slot2_addr = '0, slot3_addr = '0;
  logic [15:0] slot0_data, slot1_data, slot2_data, slot3_data;
  logic        slot0_ok, slot1_ok, slot2_ok, slot3_ok;
  logic [21:0] bus_addr;
  logic        bus_rd;
  logic        bus_ack = 1'b0;
  logic        bus_rdy = 1'b0;
  logic [15:0] bus_data = 16'd0;
  logic        busy;

  logic [21:0] exp_q [$];
  int          n_chk  = 0;
  int          n_pass = 0;

  jtvigil_rom_arb #(
    .AW(18), .OFFS0(22'h100000), .OFFS1(22'h003000), .OFFS2(22'h020000), .OFFS3(22'h3FFFF0)
  ) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .slot0_cs(slot0_cs), .slot0_addr(slot0_addr), .slot0_data(slot0_data), .slot0_ok(slot0_ok),
    .slot1_cs(slot1_cs), .slot1_addr(slot1_addr), .slot1_data(slot1_data), .slot1_ok(slot1_ok),
    .slot2_cs(slot2_cs), .slot2_addr(slot2_addr), .slot2_data(slot2_data), .slot2_ok(slot2_ok),
    .slot3_cs(slot3_cs), .slot3_addr(slot3_addr), .slot3_data(slot3_data), .slot3_ok(slot3_ok),
    .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_ack(bus_ack), .bus_rdy(bus_rdy),
    .bus_data(bus_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    slot0_cs = 1'b0; slot1_cs = 1'b0; slot2_cs = 1'b0; slot3_cs = 1'b0;
    tick();
  endtask

  // Wait for a read, check its address against the scoreboard, accept it with ack
  task automatic serve_req();
    logic [21:0] e;
    int n;
    n = 0;
    while (bus_rd !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_eq("rd_seen", 32'(bus_rd), 32'd1);
    if (exp_q.size() == 0) begin
      check_eq("sb_nonempty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("bus_addr", 32'(bus_addr), 32'(e));
    end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check_eq("rd_drop", 32'(bus_rd), 32'd0);
  endtask

  task automatic serve_rdy(input logic [15:0] d, input int gap);
    repeat (gap) tick();
    bus_rdy  = 1'b1;
    bus_data = d;
    tick();
    bus_rdy  = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) tick();
    check_eq("rst_rd", 32'(bus_rd), 32'd0);
    check_eq("rst_addr", 32'(bus_addr), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_data2", 32'(slot2_data), 32'd0);
    rst = 1'b1;
    tick();

    // 1: single slot2 fetch
    slot2_addr = 18'h00123; slot2_cs = 1'b1;
    exp_q.push_back(22'h020123);
    tick();
    check_eq("t1_rd_cycle1", 32'(bus_rd), 32'd1);
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_ok_early", 32'(slot2_ok), 32'd0);
    serve_req();
    serve_rdy(16'hBEEF, 1);
    check_eq("t1_ok", 32'(slot2_ok), 32'd1);
    check_eq("t1_data", 32'(slot2_data), 32'h0000BEEF);
    check_eq("t1_idle", 32'(busy), 32'd0);

    // 2: four requests from pointer 3, then fairness
    idle_all();
    rst = 1'b0; tick(); rst = 1'b1; tick();
    slot0_addr = 18'h40; slot1_addr = 18'h50; slot2_addr = 18'h60; slot3_addr = 18'h20;
    slot0_cs = 1'b1; slot1_cs = 1'b1; slot2_cs = 1'b1; slot3_cs = 1'b1;
    exp_q.push_back(22'h100040);
    exp_q.push_back(22'h003050);
    exp_q.push_back(22'h020060);
    exp_q.push_back(22'h000010);
    serve_req(); serve_rdy(16'h1111, 0);
    check_eq("t2_ok0", 32'(slot0_ok), 32'd1);
    serve_req(); serve_rdy(16'h2222, 2);
    check_eq("t2_ok1", 32'(slot1_ok), 32'd1);
    serve_req(); serve_rdy(16'h3333, 0);
    check_eq("t2_data2", 32'(slot2_data), 32'h3333);
    serve_req(); serve_rdy(16'h4444, 1);
    check_eq("t2_ok3", 32'(slot3_ok), 32'd1);
    check_eq("t2_data3", 32'(slot3_data), 32'h4444);
    check_eq("t2_ok0_kept", 32'(slot0_ok), 32'd1);
    idle_all();
    slot0_addr = 18'h70; slot1_addr = 18'h80; slot0_cs = 1'b1; slot1_cs = 1'b1;
    exp_q.push_back(22'h100070);
    exp_q.push_back(22'h003080);
    exp_q.push_back(22'h100071);
    serve_req(); serve_rdy(16'h5555, 0);
    slot0_addr = 18'h71;
    #1;
    check_eq("t2_ok0_newaddr", 32'(slot0_ok), 32'd0);
    serve_req(); serve_rdy(16'h6666, 0);
    check_eq("t2_ok1_fair", 32'(slot1_ok), 32'd1);
    serve_req(); serve_rdy(16'h7777, 0);
    check_eq("t2_ok0_fair", 32'(slot0_ok), 32'd1);
    check_eq("t2_data0", 32'(slot0_data), 32'h7777);

    // 3: address change during WAIT
    idle_all();
    slot1_addr = 18'h10; slot1_cs = 1'b1;
    exp_q.push_back(22'h003010);
    serve_req();
    slot1_addr = 18'h11;
    exp_q.push_back(22'h003011);
    serve_rdy(16'hA010, 1);
    check_eq("t3_ok_stale", 32'(slot1_ok), 32'd0);
    check_eq("t3_data_stale", 32'(slot1_data), 32'hA010);
    serve_req(); serve_rdy(16'hA011, 0);
    check_eq("t3_ok", 32'(slot1_ok), 32'd1);
    check_eq("t3_data", 32'(slot1_data), 32'hA011);

    // 4: cs toggle with same address
    slot1_cs = 1'b0;
    tick();
    slot1_cs = 1'b1;
    #1;
`ifdef JTVIGIL_ROM_ARB_CACHE_EN
    check_eq("t4_cache_hit", 32'(slot1_ok), 32'd1);
    tick();
    check_eq("t4_no_rd", 32'(bus_rd), 32'd0);
`else
    check_eq("t4_refetch_ok", 32'(slot1_ok), 32'd0);
    exp_q.push_back(22'h003011);
    serve_req(); serve_rdy(16'hB011, 0);
    check_eq("t4_data", 32'(slot1_data), 32'hB011);
`endif
    check_eq("t4_ok", 32'(slot1_ok), 32'd1);

    // 5: reset during WAIT
    slot3_addr = 18'h30; slot3_cs = 1'b1;
    exp_q.push_back(22'h000020);
    serve_req();
    rst = 1'b0;
    #1;
    check_eq("t5_rd", 32'(bus_rd), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_ok1", 32'(slot1_ok), 32'd0);
    check_eq("t5_ok3", 32'(slot3_ok), 32'd0);
    tick();
    rst = 1'b1;
    exp_q.push_back(22'h003011);
    exp_q.push_back(22'h000020);
    serve_req(); serve_rdy(16'hC011, 0);
    serve_req(); serve_rdy(16'hC030, 0);
    check_eq("t5_ok1_re", 32'(slot1_ok), 32'd1);
    check_eq("t5_ok3_re", 32'(slot3_ok), 32'd1);
    check_eq("t5_data3", 32'(slot3_data), 32'hC030);

    // 6: downloading blocks new reads
    idle_all();
    downloading = 1'b1;
    slot0_addr = 18'h5; slot0_cs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t6_no_rd", 32'(bus_rd), 32'd0);
      check_eq("t6_no_ok", 32'(slot0_ok), 32'd0);
    end
    downloading = 1'b0;
    exp_q.push_back(22'h100005);
    tick();
    check_eq("t6_rd_next", 32'(bus_rd), 32'd1);
    serve_req(); serve_rdy(16'hD005, 0);
    check_eq("t6_ok", 32'(slot0_ok), 32'd1);

    // 7: ack and rdy together, then stray rdy while idle
    idle_all();
    slot2_addr = 18'h7; slot2_cs = 1'b1;
    exp_q.push_back(22'h020007);
    tick();
    check_eq("t7_rd", 32'(bus_rd), 32'd1);
    if (exp_q.size() != 0) check_eq("t7_addr", 32'(bus_addr), 32'(exp_q.pop_front()));
    bus_ack = 1'b1; bus_rdy = 1'b1; bus_data = 16'h1234;
    tick();
    bus_ack = 1'b0; bus_rdy = 1'b0;
    check_eq("t7_busy", 32'(busy), 32'd0);
    check_eq("t7_ok", 32'(slot2_ok), 32'd1);
    check_eq("t7_data", 32'(slot2_data), 32'h1234);
    bus_rdy = 1'b1; bus_data = 16'hDEAD;
    tick();
    bus_rdy = 1'b0;
    tick();
    check_eq("t7_stray_rdy", 32'(slot2_data), 32'h1234);
    check_eq("t7_no_rd", 32'(bus_rd), 32'd0);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
